spike_count_classifier: RTL and testbench

- Sits directly downstream of the recurrent IF network and consumes its output spike vector.
- Accumulates per-neuron spike counts over a programmable window of timesteps (one timestep per clock).
- After the window closes, scans the counts sequentially and reports the index of the most active neuron as the classification result, with a one-cycle done pulse.
- Counts stay readable through a select/data port until the next start.

---
 rtl/spike_count_classifier.sv | 144 ++++++++++++++
 tb/tb_spike_count_classifier.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_count_classifier.sv
// Per-neuron spike counter over a programmable window, followed by a sequential
// argmax scan that reports the most active neuron with a one-cycle done pulse.
module spike_count_classifier #(
    parameter int NUM_NEURONS  = 4,
    parameter int COUNT_WIDTH  = 16,
    parameter int WINDOW_WIDTH = 16,
    parameter int SEL_WIDTH    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WINDOW_WIDTH-1:0] window_len,
    input  logic [NUM_NEURONS-1:0]  spike_in,
    output logic                    busy,
    output logic                    done,
    output logic [SEL_WIDTH-1:0]    winner,
    output logic [COUNT_WIDTH-1:0]  winner_count,
    output logic                    no_spike,
    input  logic [SEL_WIDTH-1:0]    cnt_sel,
    output logic [COUNT_WIDTH-1:0]  cnt_dout,
    output logic [1:0]              state_dbg
);

    // Handshake: start is a level sampled only while idle; done is a one-cycle
    // pulse and winner/winner_count/no_spike are valid from that cycle until
    // the next accepted start.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [COUNT_WIDTH-1:0]  counts [NUM_NEURONS];
    logic [WINDOW_WIDTH-1:0] len_q;
    logic [WINDOW_WIDTH-1:0] timestep;
    logic [SEL_WIDTH-1:0]    scan_idx;
    logic [SEL_WIDTH-1:0]    best_idx;
    logic [COUNT_WIDTH-1:0]  best_cnt;
    logic [SEL_WIDTH-1:0]    winner_q;
    logic [COUNT_WIDTH-1:0]  winner_count_q;
    logic                    no_spike_q;

    logic                    last_step;
    logic                    last_idx;
    logic [COUNT_WIDTH-1:0]  scan_cnt;
    logic                    scan_take;
    logic [SEL_WIDTH-1:0]    scan_best_idx;
    logic [COUNT_WIDTH-1:0]  scan_best_cnt;

    assign last_step = (timestep == len_q - 1'b1);
    assign last_idx  = (scan_idx == SEL_WIDTH'(NUM_NEURONS - 1));

    // Index 0 seeds the running best; later indices need a strictly larger
    // count, so the lowest index wins a tie.
    always_comb begin
        scan_cnt      = counts[scan_idx];
        scan_take     = (scan_idx == '0) || (scan_cnt > best_cnt);
        scan_best_idx = scan_take ? scan_idx : best_idx;
        scan_best_cnt = scan_take ? scan_cnt : best_cnt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_COUNT;
            S_COUNT: if (last_step) state_next = S_SCAN;
            S_SCAN:  if (last_idx) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) counts[i] <= '0;
            len_q          <= '0;
            timestep       <= '0;
            scan_idx       <= '0;
            best_idx       <= '0;
            best_cnt       <= '0;
            winner_q       <= '0;
            winner_count_q <= '0;
            no_spike_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_NEURONS; i++) counts[i] <= '0;
                        len_q          <= (window_len == '0) ? WINDOW_WIDTH'(1) : window_len;
                        timestep       <= '0;
                        scan_idx       <= '0;
                        winner_q       <= '0;
                        winner_count_q <= '0;
                        no_spike_q     <= 1'b0;
                    end
                end
                S_COUNT: begin
                    for (int i = 0; i < NUM_NEURONS; i++) begin
                        if (spike_in[i] && (counts[i] != '1)) counts[i] <= counts[i] + 1'b1;
                    end
                    timestep <= timestep + 1'b1;
                end
                S_SCAN: begin
                    best_idx <= scan_best_idx;
                    best_cnt <= scan_best_cnt;
                    if (last_idx) begin
                        // Result registers load on the edge into DONE so they are valid with done.
                        scan_idx       <= '0;
                        winner_q       <= scan_best_idx;
                        winner_count_q <= scan_best_cnt;
                        no_spike_q     <= (scan_best_cnt == '0);
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_dout = '0;
        if (int'(cnt_sel) < NUM_NEURONS) cnt_dout = counts[cnt_sel];
    end

    assign busy         = (state == S_COUNT) || (state == S_SCAN);
    assign done         = (state == S_DONE);
    assign winner       = winner_q;
    assign winner_count = winner_count_q;
    assign no_spike     = no_spike_q;
    assign state_dbg    = state;

endmodule

// File: tb/tb_spike_count_classifier.sv
// Bench for spike_count_classifier: a 16-bit and a 4-bit-count instance share
// stimulus and are compared against a counting/argmax reference model.
module tb_spike_count_classifier;

    localparam int N   = 4;
    localparam int CW  = 16;
    localparam int CWS = 4;
    localparam int WW  = 16;
    localparam int SW  = 2;
    localparam int RW  = 1 + SW + CW;
    localparam int SAT_MAX = (1 << CWS) - 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic [WW-1:0] window_len;
    logic [N-1:0]  spike_in;
    logic [SW-1:0] cnt_sel;

    logic          busy, done, no_spike;
    logic [SW-1:0] winner;
    logic [CW-1:0] winner_count, cnt_dout;
    logic [1:0]    state_dbg;

    logic           busy_s, done_s, no_spike_s;
    logic [SW-1:0]  winner_s;
    logic [CWS-1:0] winner_count_s, cnt_dout_s;
    logic [1:0]     state_dbg_s;

    spike_count_classifier #(.NUM_NEURONS(N), .COUNT_WIDTH(CW), .WINDOW_WIDTH(WW)) dut (
        .clk(clk), .rst(rst), .start(start), .window_len(window_len), .spike_in(spike_in),
        .busy(busy), .done(done), .winner(winner), .winner_count(winner_count),
        .no_spike(no_spike), .cnt_sel(cnt_sel), .cnt_dout(cnt_dout), .state_dbg(state_dbg)
    );

    spike_count_classifier #(.NUM_NEURONS(N), .COUNT_WIDTH(CWS), .WINDOW_WIDTH(WW)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .window_len(window_len), .spike_in(spike_in),
        .busy(busy_s), .done(done_s), .winner(winner_s), .winner_count(winner_count_s),
        .no_spike(no_spike_s), .cnt_sel(cnt_sel), .cnt_dout(cnt_dout_s), .state_dbg(state_dbg_s)
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0]  pat[$];
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] exp_sat_q[$];
    int            exp_cnt[N];
    int            exp_cnt_s[N];
    logic [RW-1:0] last_res;
    logic [RW-1:0] last_res_s;

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: find the maximum count, then the first neuron holding it.
    function automatic logic [RW-1:0] pick(input int c[N]);
        int best;
        int idx;
        best = 0;
        for (int i = 0; i < N; i++) if (c[i] > best) best = c[i];
        idx = 0;
        for (int i = N - 1; i >= 0; i--) if (c[i] == best) idx = i;
        return {(best == 0), SW'(idx), CW'(best)};
    endfunction

    task automatic build_expect(input int eff);
        for (int i = 0; i < N; i++) begin
            int tot;
            tot = 0;
            for (int k = 0; k < eff; k++) tot += int'(pat[k][i]);
            exp_cnt[i]   = tot;
            exp_cnt_s[i] = (tot > SAT_MAX) ? SAT_MAX : tot;
        end
        exp_q.push_back(pick(exp_cnt));
        exp_sat_q.push_back(pick(exp_cnt_s));
    endtask

    // Driver: one full window; inputs change on negedge, outputs checked there too.
    task automatic run_window(input int len, input bit poke);
        int eff;
        logic [RW-1:0] e;
        logic [RW-1:0] es;
        eff = (len == 0) ? 1 : len;
        build_expect(eff);
        @(negedge clk);
        check("hold_result", {no_spike, winner, winner_count}, last_res);
        check("hold_result_s", {no_spike_s, winner_s, CW'(winner_count_s)}, last_res_s);
        start      = 1'b1;
        window_len = WW'(len);
        spike_in   = N'($urandom);
        for (int k = 1; k <= eff + N + 1; k++) begin
            @(negedge clk);
            start    = poke && (k == 2 || k == eff + 2);
            spike_in = (k <= eff) ? pat[k-1] : N'($urandom);
            if (k == 1) begin
                cnt_sel = SW'($urandom_range(0, N - 1));
                #1;
                check("cleared", cnt_dout, 0);
                check("cleared_s", cnt_dout_s, 0);
            end
            if (k > eff && k <= eff + N) begin
                cnt_sel = SW'(k - eff - 1);
                #1;
                check("cnt_dout", cnt_dout, exp_cnt[k-eff-1]);
                check("cnt_dout_s", cnt_dout_s, exp_cnt_s[k-eff-1]);
            end
            check("busy", busy, (k <= eff + N));
            check("busy_s", busy_s, (k <= eff + N));
            check("done", done, (k == eff + N + 1));
            check("done_s", done_s, (k == eff + N + 1));
            if (k == eff + N + 1) begin
                e  = exp_q.pop_front();
                es = exp_sat_q.pop_front();
                check("winner", winner, e[CW +: SW]);
                check("winner_count", winner_count, e[CW-1:0]);
                check("no_spike", no_spike, e[RW-1]);
                check("winner_s", winner_s, es[CW +: SW]);
                check("winner_count_s", winner_count_s, es[CW-1:0]);
                check("no_spike_s", no_spike_s, es[RW-1]);
                last_res   = e;
                last_res_s = es;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start    = 1'b0;
            spike_in = N'($urandom);
        end
    endtask

    task automatic async_reset_test();
        @(negedge clk);
        start      = 1'b1;
        window_len = WW'(20);
        @(negedge clk);
        start    = 1'b0;
        spike_in = '1;
        repeat (3) @(negedge clk);
        cnt_sel = '0;
        #1;
        check("pre_reset_cnt", cnt_dout, 3);
        #1;
        rst = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_busy_s", busy_s, 0);
        check("rst_winner", winner, 0);
        check("rst_winner_count", winner_count, 0);
        for (int s = 0; s < N; s++) begin
            cnt_sel = SW'(s);
            #1;
            check("rst_cnt", cnt_dout, 0);
            check("rst_cnt_s", cnt_dout_s, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (30) begin
            @(negedge clk);
            spike_in = N'($urandom);
            check("no_done_after_abort", done, 0);
            check("no_busy_after_abort", busy, 0);
        end
        last_res   = '0;
        last_res_s = '0;
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        window_len = '0;
        spike_in   = '0;
        cnt_sel    = '0;
        last_res   = '0;
        last_res_s = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_winner", winner, 0);
        check("reset_winner_count", winner_count, 0);
        check("reset_no_spike", no_spike, 0);
        check("reset_cnt", cnt_dout, 0);
        rst = 1'b1;
        idle(2);

        // Basic: neuron 2 every cycle, neuron 1 every other cycle.
        pat.delete();
        for (int k = 0; k < 10; k++) pat.push_back({1'b0, 1'b1, (k % 2 == 0), 1'b0});
        run_window(10, 1'b0);
        idle(1);

        // Tie between neurons 1 and 3, with ignored starts in COUNT and SCAN.
        pat.delete();
        for (int k = 0; k < 8; k++) pat.push_back((k % 2 == 0) ? 4'b0010 : 4'b1000);
        run_window(8, 1'b1);

        // Back-to-back: silent zero-length window.
        pat.delete();
        pat.push_back(4'b0000);
        run_window(0, 1'b0);
        idle(2);

        // Saturation on the 4-bit instance.
        pat.delete();
        for (int k = 0; k < 20; k++) pat.push_back(4'b0001);
        run_window(20, 1'b1);

        repeat (6) begin
            int len;
            idle($urandom_range(0, 2));
            len = $urandom_range(0, 12);
            pat.delete();
            for (int k = 0; k < ((len == 0) ? 1 : len); k++) pat.push_back(N'($urandom));
            run_window(len, 1'($urandom_range(0, 1)));
        end

        async_reset_test();

        pat.delete();
        for (int k = 0; k < 7; k++) pat.push_back(N'($urandom));
        run_window(7, 1'b0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
